// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential reverse double-dabble converter, NUM_SEGMENTS packed BCD digits -> 32-bit unsigned binary.
// Latency: valid pulses NUM_SEGMENTS*4 edges after the accepting edge; one conversion per NUM_SEGMENTS*4+2 cycles.
// Backpressure: start is honoured only while ready=1; requests during SHIFT/DONE are dropped, never queued.
module bcd_to_bin #(
   parameter int NUM_SEGMENTS = 8,
   parameter int CNT_W        = $clog2(NUM_SEGMENTS*4+1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [NUM_SEGMENTS*4-1:0] bcd_in,
   output logic                      ready,
   output logic                      busy,
   output logic                      valid,
   output logic [31:0]               bin_out,
   output logic                      error
);

   // Width of both the BCD field and the binary field of the shift register.
   localparam int W = NUM_SEGMENTS*4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     bcd_q;
   logic [W-1:0]     bin_q;
   logic [W-1:0]     bcd_sh;
   logic [W-1:0]     bcd_adj;
   logic [W-1:0]     bin_sh;
   logic             err_q;
   logic             in_err;
   logic             last_shift;

   // Flag any incoming digit outside 0..9; evaluated only when a request is accepted.
   always_comb begin
      in_err = 1'b0;
      for (int i = 0; i < NUM_SEGMENTS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) begin
            in_err = 1'b1;
         end
      end
   end

   // One reverse double-dabble step: shift {bcd,bin} right by one, then pull every
   // BCD digit that is now >= 8 back down by 3 (digits are independent, no carry).
   always_comb begin
      bin_sh  = {bcd_q[0], bin_q[W-1:1]};
      bcd_sh  = {1'b0, bcd_q[W-1:1]};
      bcd_adj = bcd_sh;
      for (int i = 0; i < NUM_SEGMENTS; i++) begin
         if (bcd_sh[4*i +: 4] >= 4'd8) begin
            bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
         end
      end
      last_shift = (state == SHIFT) && (cnt == CNT_W'(1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after the last shift, DONE -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decode directly from the state, so they are mutually exclusive.
   always_comb begin
      ready = (state == IDLE);
      busy  = (state == SHIFT);
      valid = (state == DONE);
   end

   // Datapath: load on accept, shift while converting, publish result on the edge entering DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         bcd_q   <= '0;
         bin_q   <= '0;
         err_q   <= 1'b0;
         bin_out <= '0;
         error   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bcd_q <= bcd_in;
                  bin_q <= '0;
                  err_q <= in_err;
                  cnt   <= CNT_W'(W);
               end
            end
            SHIFT: begin
               bcd_q <= bcd_adj;
               bin_q <= bin_sh;
               cnt   <= cnt - CNT_W'(1);
               if (last_shift) begin
                  // Illegal digits still run the full length but report zero.
                  bin_out <= err_q ? 32'd0 : 32'(bin_sh);
                  error   <= err_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: scoreboard bench for bcd_to_bin, default (8-digit) and 4-digit builds side by side.
// Expected results come from a decimal reference model; a monitor pops and compares on every valid.
// Directed cases first, then randomized back-to-back traffic with start held high.
module tb_bcd_to_bin;

   logic        clk = 1'b0;
   logic        reset;
   logic        start8, start4;
   logic [31:0] bcd8;
   logic [15:0] bcd4;
   logic        ready8, busy8, valid8, error8;
   logic        ready4, busy4, valid4, error4;
   logic [31:0] bin8, bin4;

   always #5 clk = ~clk;

   bcd_to_bin dut8 (
      .clk(clk), .reset(reset), .start(start8), .bcd_in(bcd8),
      .ready(ready8), .busy(busy8), .valid(valid8), .bin_out(bin8), .error(error8)
   );

   bcd_to_bin #(.NUM_SEGMENTS(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .bcd_in(bcd4),
      .ready(ready4), .busy(busy4), .valid(valid4), .bin_out(bin4), .error(error4)
   );

   typedef struct {
      logic [31:0] bin;
      logic        err;
      int          acc;
   } exp_t;

   exp_t        sb[2][$];
   logic [31:0] last_bin[2];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   // Reference model: weigh each decimal digit, flag any digit above 9.
   function automatic exp_t model(input logic [31:0] b, input int nseg, input int acc);
      exp_t    e;
      longint  v;
      logic    bad;
      int      d;
      v   = 0;
      bad = 1'b0;
      for (int i = nseg - 1; i >= 0; i--) begin
         d = int'((b >> (4*i)) & 32'hF);
         if (d > 9) bad = 1'b1;
         v = v * 10 + d;
      end
      e.bin = bad ? 32'd0 : v[31:0];
      e.err = bad;
      e.acc = acc;
      return e;
   endfunction

   function automatic logic [31:0] to_bcd(input int unsigned n, input int nseg);
      logic [31:0] r;
      int unsigned x;
      r = '0;
      x = n;
      for (int i = 0; i < nseg; i++) begin
         r = r | (32'(x % 10) << (4*i));
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] gen(input int nseg);
      int unsigned maxv;
      int unsigned sel;
      logic [31:0] mask;
      maxv = (nseg == 8) ? 32'd99999999 : 32'd9999;
      mask = (nseg == 8) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      sel  = $urandom_range(15);
      if (sel == 0)      return $urandom() & mask;
      else if (sel == 1) return to_bcd(maxv, nseg);
      else if (sel == 2) return 32'd0;
      else               return to_bcd($urandom_range(maxv), nseg);
   endfunction

   // Monitor: runs just after every rising edge, independent of stimulus.
   task automatic mon(input int k, input int w, input logic rdy, input logic bsy, input logic vld,
                      input logic [31:0] bo, input logic er);
      exp_t e;
      check($sformatf("onehot%0d", w), {31'd0, rdy} + {31'd0, bsy} + {31'd0, vld}, 32'd1);
      if (vld) begin
         if (sb[k].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_valid%0d: got valid with bin_out=0x%h, expected no valid", w, bo);
         end else begin
            e = sb[k].pop_front();
            check($sformatf("bin_out%0d", w), bo, e.bin);
            check($sformatf("error%0d", w), {31'd0, er}, {31'd0, e.err});
            check($sformatf("latency%0d", w), 32'(cyc - e.acc), 32'(w));
         end
      end else if (!reset) begin
         check($sformatf("hold%0d", w), bo, last_bin[k]);
      end
      last_bin[k] = bo;
   endtask

   always @(posedge clk) begin
      #1;
      mon(0, 32, ready8, busy8, valid8, bin8, error8);
      mon(1, 16, ready4, busy4, valid4, bin4, error4);
   end

   // Drive one cycle of the 8-digit port; record an expectation if this edge will accept.
   task automatic drive8(input logic s, input logic [31:0] b);
      @(negedge clk);
      start8 = s;
      bcd8   = b;
      if (s && ready8 && !reset) sb[0].push_back(model(b, 8, cyc + 1));
   endtask

   task automatic wait_ready8(output int nbusy);
      int guard;
      nbusy = 0;
      guard = 0;
      while (!ready8 && guard < 100) begin
         if (busy8) nbusy++;
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL timeout_ready8: ready still 0 after %0d cycles, expected 1", guard);
      end
   endtask

   task automatic convert8(input logic [31:0] b);
      int nb;
      drive8(1'b1, b);
      @(negedge clk);
      start8 = 1'b0;
      wait_ready8(nb);
      check("busy_cycles8", 32'(nb), 32'd32);
   endtask

   initial begin
      int          nb;
      int          prev[2];
      int          guard;
      logic [31:0] dir[5];

      last_bin[0] = '0;
      last_bin[1] = '0;
      reset  = 1'b1;
      start8 = 1'b0;
      start4 = 1'b0;
      bcd8   = '0;
      bcd4   = '0;
      repeat (3) @(negedge clk);
      check("rst_ready8", {31'd0, ready8}, 32'd1);
      check("rst_busy8",  {31'd0, busy8},  32'd0);
      check("rst_valid8", {31'd0, valid8}, 32'd0);
      check("rst_bin8",   bin8,            32'd0);
      check("rst_err8",   {31'd0, error8}, 32'd0);
      check("rst_ready4", {31'd0, ready4}, 32'd1);
      check("rst_bin4",   bin4,            32'd0);
      reset = 1'b0;

      // Directed conversions, including an illegal digit and its recovery.
      dir[0] = 32'h12345678;
      dir[1] = 32'h99999999;
      dir[2] = 32'h00000000;
      dir[3] = 32'h0000001A;
      dir[4] = 32'h00000042;
      foreach (dir[i]) convert8(dir[i]);

      // A second start mid-conversion must be dropped.
      drive8(1'b1, 32'h11111111);
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      drive8(1'b1, 32'h22222222);
      @(negedge clk);
      start8 = 1'b0;
      wait_ready8(nb);
      repeat (40) @(negedge clk);
      check("ignored_start_sb_empty", 32'(sb[0].size()), 32'd0);

      // Reset in the middle of a conversion aborts it without a valid.
      drive8(1'b1, 32'h87654321);
      @(negedge clk);
      start8 = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      sb[0].delete();
      @(negedge clk);
      reset = 1'b0;
      check("midrst_ready8", {31'd0, ready8}, 32'd1);
      check("midrst_busy8",  {31'd0, busy8},  32'd0);
      check("midrst_valid8", {31'd0, valid8}, 32'd0);
      check("midrst_bin8",   bin8,            32'd0);
      check("midrst_err8",   {31'd0, error8}, 32'd0);
      repeat (40) @(negedge clk);
      convert8(32'h31415926);

      // Randomized back-to-back traffic on both builds with start held high.
      prev[0] = -1;
      prev[1] = -1;
      for (int c = 0; c < 12000; c++) begin
         @(negedge clk);
         start8 = 1'b1;
         start4 = 1'b1;
         bcd8   = gen(8);
         bcd4   = 16'(gen(4));
         if (ready8) begin
            sb[0].push_back(model(bcd8, 8, cyc + 1));
            if (prev[0] >= 0) check("throughput8", 32'(cyc + 1 - prev[0]), 32'd34);
            prev[0] = cyc + 1;
         end
         if (ready4) begin
            sb[1].push_back(model({16'd0, bcd4}, 4, cyc + 1));
            if (prev[1] >= 0) check("throughput4", 32'(cyc + 1 - prev[1]), 32'd18);
            prev[1] = cyc + 1;
         end
      end
      @(negedge clk);
      start8 = 1'b0;
      start4 = 1'b0;
      guard  = 0;
      while ((sb[0].size() != 0 || sb[1].size() != 0) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("drain8", 32'(sb[0].size()), 32'd0);
      check("drain4", 32'(sb[1].size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
